// File: rtl/legv8_fetch_pkg.sv
// legv8_fetch_pkg: shared widths, fetch increment and redirect FSM states for the fetch PC unit
package legv8_fetch_pkg;
  localparam int ADDR_W = 64;
  localparam int INSN_BYTES_C = 4;
  typedef enum logic [0:0] {RUN = 1'b0, PENDING = 1'b1} redirect_state_t;
endpackage

// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: RF-stage branch handshake plus fetch-side outputs of the PC redirect unit
interface pc_redirect_unit_if;
  import legv8_fetch_pkg::*;
  logic stall;
  logic br_valid;
  logic br_taken;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] br_offset;
  logic br_ack;
  logic [ADDR_W-1:0] pc;
  logic flush_if;
  logic [31:0] taken_cnt;
  logic [31:0] ntaken_cnt;
  modport master(output stall, br_valid, br_taken, br_pc, br_offset,
                 input br_ack, pc, flush_if, taken_cnt, ntaken_cnt);
  modport slave(input stall, br_valid, br_taken, br_pc, br_offset,
                output br_ack, pc, flush_if, taken_cnt, ntaken_cnt);
endinterface

// File: rtl/pc_target_adder.sv
// pc_target_adder: combinational branch target, br_pc + br_offset with silent 64-bit wrap
module pc_target_adder
  import legv8_fetch_pkg::*;
(
  input  logic [ADDR_W-1:0] i_br_pc,
  input  logic [ADDR_W-1:0] i_br_offset,
  output logic [ADDR_W-1:0] o_target
);
  assign o_target = i_br_pc + i_br_offset;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC owner that redirects on taken branches, deferring across stalls
// Optional branch statistics counters are built when REDIRECT_STATS_EN is defined.
module pc_redirect_unit
  import legv8_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int INSN_BYTES = INSN_BYTES_C
) (
  input logic clk,
  input logic reset,
  pc_redirect_unit_if.slave bus
);
  redirect_state_t r_state;
  logic [ADDR_W-1:0] r_pc, r_pending, w_target, w_seq_pc;
  logic r_ack, r_flush, w_accept, w_taken;
  pc_target_adder u_adder (
    .i_br_pc(bus.br_pc),
    .i_br_offset(bus.br_offset),
    .o_target(w_target)
  );
  assign w_seq_pc = bus.stall ? r_pc : r_pc + ADDR_W'(INSN_BYTES);
  // br_valid is still high the cycle after an ack while RF drops it; ignore it then
  assign w_accept = (r_state == RUN) && bus.br_valid && !r_ack;
  assign w_taken = w_accept && bus.br_taken;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_pc <= RESET_PC;
      r_pending <= '0;
      r_ack <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_ack <= w_accept;
      r_flush <= w_taken;
      if (r_state == PENDING) begin
        if (!bus.stall) begin
          r_pc <= r_pending;
          r_state <= RUN;
        end
      end else if (w_taken && bus.stall) begin
        r_pending <= w_target;
        r_state <= PENDING;
      end else begin
        r_pc <= w_taken ? w_target : w_seq_pc;
      end
    end
  end
  assign bus.pc = r_pc;
  assign bus.br_ack = r_ack;
  assign bus.flush_if = r_flush;
`ifdef REDIRECT_STATS_EN
  logic [31:0] r_taken_cnt, r_ntaken_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_taken_cnt <= '0;
      r_ntaken_cnt <= '0;
    end else begin
      if (w_taken && !(&r_taken_cnt)) r_taken_cnt <= r_taken_cnt + 32'd1;
      if (w_accept && !bus.br_taken && !(&r_ntaken_cnt)) r_ntaken_cnt <= r_ntaken_cnt + 32'd1;
    end
  end
  assign bus.taken_cnt = r_taken_cnt;
  assign bus.ntaken_cnt = r_ntaken_cnt;
`else
  assign bus.taken_cnt = '0;
  assign bus.ntaken_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: table-driven directed test of pc_redirect_unit plus reset and counter sequences
module tb_pc_redirect_unit;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
`ifdef REDIRECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  pc_redirect_unit_if bus();
  pc_redirect_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic stall, valid, taken;
    logic [63:0] bpc, boff, pc;
    logic ack, flush;
    logic [31:0] tc, nc;
  } vec_t;
  vec_t v[16];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic s, input logic bv, input logic bt, input logic [63:0] bp, input logic [63:0] bo);
    bus.stall = s;
    bus.br_valid = bv;
    bus.br_taken = bt;
    bus.br_pc = bp;
    bus.br_offset = bo;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cnt(input string name, input logic [31:0] tc, input logic [31:0] nc);
    chk({name, "_taken_cnt"}, 64'(bus.taken_cnt), STATS ? 64'(tc) : 64'h0);
    chk({name, "_ntaken_cnt"}, 64'(bus.ntaken_cnt), STATS ? 64'(nc) : 64'h0);
  endtask
  initial begin
    v[0]  = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h4, 1'b0, 1'b0, 32'd0, 32'd0};
    v[1]  = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h8, 1'b0, 1'b0, 32'd0, 32'd0};
    v[2]  = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'hC, 1'b0, 1'b0, 32'd0, 32'd0};
    v[3]  = '{1'b0, 1'b1, 1'b1, 64'h100, 64'h40, 64'h140, 1'b1, 1'b1, 32'd1, 32'd0};
    v[4]  = '{1'b0, 1'b1, 1'b1, 64'h100, 64'h40, 64'h144, 1'b0, 1'b0, 32'd1, 32'd0};
    v[5]  = '{1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h144, 1'b0, 1'b0, 32'd1, 32'd0};
    v[6]  = '{1'b1, 1'b1, 1'b1, 64'h200, 64'hFFFF_FFFF_FFFF_FFF8, 64'h144, 1'b1, 1'b1, 32'd2, 32'd0};
    v[7]  = '{1'b1, 1'b1, 1'b1, 64'h200, 64'hFFFF_FFFF_FFFF_FFF8, 64'h144, 1'b0, 1'b0, 32'd2, 32'd0};
    v[8]  = '{1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h144, 1'b0, 1'b0, 32'd2, 32'd0};
    v[9]  = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h1F8, 1'b0, 1'b0, 32'd2, 32'd0};
    v[10] = '{1'b0, 1'b1, 1'b1, 64'h40, 64'h40, 64'h80, 1'b1, 1'b1, 32'd3, 32'd0};
    v[11] = '{1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h80, 1'b0, 1'b0, 32'd3, 32'd0};
    v[12] = '{1'b0, 1'b1, 1'b0, 64'h80, 64'h0, 64'h84, 1'b1, 1'b0, 32'd3, 32'd1};
    v[13] = '{1'b0, 1'b1, 1'b0, 64'h80, 64'h0, 64'h88, 1'b0, 1'b0, 32'd3, 32'd1};
    v[14] = '{1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h4, 1'b1, 1'b1, 32'd4, 32'd1};
    v[15] = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h8, 1'b0, 1'b0, 32'd4, 32'd1};
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    step();
    step();
    chk("reset_pc", bus.pc, 64'h0);
    chk("reset_ack", 64'(bus.br_ack), 64'h0);
    chk("reset_flush", 64'(bus.flush_if), 64'h0);
    chk_cnt("reset", 32'd0, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(v[i].stall, v[i].valid, v[i].taken, v[i].bpc, v[i].boff);
      step();
      chk($sformatf("vec%0d_pc", i), bus.pc, v[i].pc);
      chk($sformatf("vec%0d_ack", i), 64'(bus.br_ack), 64'(v[i].ack));
      chk($sformatf("vec%0d_flush", i), 64'(bus.flush_if), 64'(v[i].flush));
      chk_cnt($sformatf("vec%0d", i), v[i].tc, v[i].nc);
    end
    drive(1'b1, 1'b1, 1'b1, 64'h300, 64'h10);
    step();
    chk("pend_pc_hold", bus.pc, 64'h8);
    chk("pend_ack", 64'(bus.br_ack), 64'h1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    step();
    chk("rstpend_pc", bus.pc, 64'h0);
    chk("rstpend_ack", 64'(bus.br_ack), 64'h0);
    chk("rstpend_flush", 64'(bus.flush_if), 64'h0);
    chk_cnt("rstpend", 32'd0, 32'd0);
    reset = 1'b0;
    step();
    chk("rstpend_no_apply_pc", bus.pc, 64'h4);
    drive(1'b0, 1'b1, 1'b1, 64'h100, 64'h40);
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    step();
    drive(1'b0, 1'b1, 1'b1, 64'h200, 64'h10);
    step();
    chk("cnt_second_taken_pc", bus.pc, 64'h210);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    step();
    drive(1'b0, 1'b1, 1'b0, 64'h214, 64'h0);
    step();
    chk("cnt_ntaken_ack", 64'(bus.br_ack), 64'h1);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    step();
    chk("cnt_final_pc", bus.pc, 64'h21C);
    chk_cnt("cnt_final", 32'd2, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
